// File: rtl/mux_sel_pipe.sv
// N-input WIDTH-bit select mux feeding a two-entry valid/ready skid buffer.
// Out-of-range selects fall back to the highest-index input; flush empties the buffer.
module mux_sel_pipe #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned N     = 3,
  parameter int unsigned SELW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         occupancy
);

  if (N < 2 || N > 16 || (2 ** SELW) < N) begin : g_param_err
    $error("mux_sel_pipe: N must be 2..16 and 2**SELW >= N");
  end

  logic [WIDTH-1:0] sel_val;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [1:0]       occ_q, occ_d;
  logic             in_ready_q, out_valid_q;
  logic             accept, pop;

  // Default to the highest input so an out-of-range select never yields X or 0.
  always_comb begin
    sel_val = in_data[(N-1)*WIDTH +: WIDTH];
    for (int i = 0; i < int'(N) - 1; i++) begin
      if (sel == SELW'(i)) begin
        sel_val = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush) begin
      occ_d = 2'd0;
    end else begin
      unique case (occ_q)
        2'd0: begin
          if (accept) begin
            occ_d  = 2'd1;
            head_d = sel_val;
          end
        end
        2'd1: begin
          if (accept && pop) begin
            head_d = sel_val;
          end else if (accept) begin
            occ_d  = 2'd2;
            skid_d = sel_val;
          end else if (pop) begin
            occ_d = 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            occ_d  = 2'd1;
            head_d = skid_q;
          end
        end
        default: occ_d = 2'd0;
      endcase
    end
  end

  // Handshake flags are registered from the next occupancy so in_ready has no
  // combinational path from out_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q       <= 2'd0;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= (occ_d != 2'd2);
      out_valid_q <= (occ_d != 2'd0);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Self-checking bench for mux_sel_pipe: directed plan steps plus random traffic
// against a queue-based reference model.
module tb_mux_sel_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] in_data;
  logic [1:0]  sel;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [4:0]  out_data;
  logic [1:0]  occupancy;

  logic [24:0] in_data5;
  logic [2:0]  sel5;
  logic        in_valid5, in_ready5, out_valid5, out_ready5;
  logic [4:0]  out_data5;
  logic [1:0]  occupancy5;

  int checks = 0;
  int errors = 0;

  logic [4:0] q[$];
  logic [4:0] last_out = 5'd0;

  always #5 clk = ~clk;

  mux_sel_pipe u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .occupancy(occupancy)
  );

  mux_sel_pipe #(.WIDTH(5), .N(5), .SELW(3)) u_dut5 (
    .clk(clk), .rst(rst), .in_data(in_data5), .sel(sel5), .in_valid(in_valid5),
    .in_ready(in_ready5), .flush(1'b0), .out_data(out_data5), .out_valid(out_valid5),
    .out_ready(out_ready5), .occupancy(occupancy5)
  );

  function automatic logic [4:0] pick(input logic [24:0] d, input int s, input int n);
    int idx;
    idx = (s < n) ? s : n - 1;
    return 5'((d >> (idx * 5)) & 25'h1f);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = q.size();
    check("occupancy", 32'(occupancy), 32'(n));
    check("out_valid", 32'(out_valid), 32'(n != 0));
    check("in_ready", 32'(in_ready), 32'(n != 2));
    check("out_data", 32'(out_data), 32'((n != 0) ? q[0] : last_out));
  endtask

  // Compare current outputs, advance the model by one clock, then move to the next negedge.
  task automatic cycle();
    int  n;
    bit  acc, pp;
    logic [4:0] cur;
    check_outputs();
    n   = q.size();
    acc = in_valid && (n != 2);
    pp  = (n != 0) && out_ready;
    cur = (n != 0) ? q[0] : last_out;
    last_out = cur;
    if (flush) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(pick(25'(in_data), int'(sel), 3));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input bit r, input bit f);
    in_valid  = v;
    sel       = s;
    out_ready = r;
    flush     = f;
  endtask

  initial begin
    rst = 1'b0; in_data = 15'd0; sel = 2'd0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_data5 = 25'd0; sel5 = 3'd0; in_valid5 = 1'b0; out_ready5 = 1'b1;

    // Reset then idle.
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) cycle();

    // Streaming with in-range and out-of-range selects.
    in_data = {5'd31, 5'd7, 5'd3};
    drive(1'b1, 2'd0, 1'b1, 1'b0); cycle();
    drive(1'b1, 2'd1, 1'b1, 1'b0); cycle();
    drive(1'b1, 2'd2, 1'b1, 1'b0); cycle();
    drive(1'b1, 2'd3, 1'b1, 1'b0); cycle();
    drive(1'b0, 2'd0, 1'b1, 1'b0); cycle();
    check("sel3_is_input2", 32'(out_data), 32'd31);
    cycle();

    // Back-pressure: A, B fill, C ignored while full, then drained and re-offered.
    drive(1'b1, 2'd0, 1'b0, 1'b0); cycle();
    drive(1'b1, 2'd1, 1'b0, 1'b0); cycle();
    drive(1'b1, 2'd2, 1'b0, 1'b0); cycle();
    cycle();
    drive(1'b0, 2'd2, 1'b1, 1'b0); cycle();
    cycle();
    cycle();
    drive(1'b1, 2'd2, 1'b1, 1'b0); cycle();
    drive(1'b0, 2'd0, 1'b1, 1'b0); cycle();
    cycle();

    // Flush while full with a simultaneous offer.
    drive(1'b1, 2'd0, 1'b0, 1'b0); cycle();
    drive(1'b1, 2'd1, 1'b0, 1'b0); cycle();
    drive(1'b1, 2'd2, 1'b1, 1'b1); cycle();
    drive(1'b0, 2'd0, 1'b1, 1'b0); cycle();
    cycle();

    // Asynchronous reset while full, between clock edges.
    drive(1'b1, 2'd0, 1'b0, 1'b0); cycle();
    drive(1'b1, 2'd1, 1'b0, 1'b0); cycle();
    check_outputs();
    #2 rst = 1'b0;
    #1;
    q.delete();
    last_out = 5'd0;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_occ", 32'(occupancy), 32'd0);
    check_outputs();
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cycle();
    drive(1'b1, 2'd2, 1'b1, 1'b0); cycle();
    drive(1'b0, 2'd0, 1'b1, 1'b0); cycle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_data = 15'($urandom);
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      cycle();
    end
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    cycle();
    cycle();

    // Wider instance: N=5, SELW=3, every select value including out-of-range.
    for (int s = 0; s < 8; s++) begin
      logic [24:0] d;
      d = 25'($urandom);
      in_data5  = d;
      sel5      = 3'(s);
      in_valid5 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_data5 = ~d;
      check("n5_valid", 32'(out_valid5), 32'd1);
      check("n5_data", 32'(out_data5), 32'(pick(d, s, 5)));
    end
    in_valid5 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
